// File: rtl/apb_reg_responder_if.sv
// APB completer-side bus bundle for apb_reg_responder.
// Requester drives addr/ctrl/data; completer drives pready/prdata/pslverr.
interface apb_reg_responder_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable,
    output in_pprot, in_pwrite, in_pwdata,
    output in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable,
    input  in_pprot, in_pwrite, in_pwdata,
    input  in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/apb_reg_responder.sv
// APB register responder: DEPTH storage words, WAIT_CFG, ACCESS_CNT.
// Ports: clock, reset (sync, active-high), bus (APB slave modport).
module apb_reg_responder #(
  parameter int WAIT  = 2,
  parameter int DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  apb_reg_responder_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [31:0] mem [DEPTH];
  logic [7:0]  wait_cfg;
  logic [31:0] acc_cnt;

  logic [11:0]   off;
  logic [AW-1:0] widx;
  logic          is_mem, is_wcfg, is_acnt;
  logic          wr, err, done;
  logic [31:0]   rdata;

  logic unused;
  assign unused = ^{bus.in_paddr[31:12],
                    bus.in_pprot[2:1]};

  assign off  = bus.in_paddr[11:0];
  assign widx = off[AW+1:2];
  assign wr   = bus.in_pwrite;

  // Misaligned offsets fall through every decode and become errors.
  assign is_mem  = (off[1:0] == 2'b00) &&
                   (off[11:2] < 10'(DEPTH));
  assign is_wcfg = (off == 12'h100);
  assign is_acnt = (off == 12'h104);

  assign err = !(is_mem || is_wcfg || is_acnt)
             || (wr && is_acnt)
             || (wr && is_wcfg && !bus.in_pprot[0]);

  assign done = (state == ACCESS) && (cnt == 8'd0)
             && bus.in_psel && bus.in_penable
             && !reset;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_mem:  rdata = mem[widx];
      is_wcfg: rdata = {24'd0, wait_cfg};
      is_acnt: rdata = acc_cnt;
      default: rdata = '0;
    endcase
  end

  assign bus.in_pready  = done;
  assign bus.in_prdata  = (done && !err && !wr) ? rdata : '0;
  assign bus.in_pslverr = done && err;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.in_psel && !bus.in_penable) begin
          state_nx = ACCESS;
          cnt_nx   = wait_cfg;
        end
      end
      ACCESS: begin
        if (bus.in_psel && bus.in_penable) begin
          if (cnt == 8'd0) state_nx = IDLE;
          else             cnt_nx   = cnt - 8'd1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wait_cfg <= 8'(WAIT);
      acc_cnt  <= '0;
      mem      <= '{default: '0};
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (done) acc_cnt <= acc_cnt + 32'd1;
      if (done && wr && !err) begin
        if (is_mem) begin
          for (int k = 0; k < 4; k++)
            if (bus.in_pstrb[k])
              mem[widx][8*k +: 8] <=
                bus.in_pwdata[8*k +: 8];
        end
        if (is_wcfg && bus.in_pstrb[0])
          wait_cfg <= bus.in_pwdata[7:0];
      end
    end
  end
endmodule

// File: tb/tb_apb_reg_responder.sv
// Directed self-checking bench for apb_reg_responder.
// Linear step sequence with immediate-assertion checks.
module tb_apb_reg_responder;
  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  apb_reg_responder_if bus ();

  apb_reg_responder #(.WAIT(2), .DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Starts at #1 after a rising edge; returns the same way,
  // so consecutive calls run back-to-back.
  task automatic xfer(input  logic        wr,
                      input  logic [31:0] a,
                      input  logic [31:0] d,
                      input  logic [3:0]  s,
                      input  logic [2:0]  p,
                      output logic [31:0] rd,
                      output logic        er,
                      output int          waits,
                      output logic        leak);
    bus.in_psel    = 1'b1;
    bus.in_penable = 1'b0;
    bus.in_pwrite  = wr;
    bus.in_paddr   = a;
    bus.in_pwdata  = d;
    bus.in_pstrb   = s;
    bus.in_pprot   = p;
    rd    = '0;
    er    = 1'b0;
    waits = 0;
    leak  = 1'b0;
    @(negedge clock);
    if (bus.in_pready || bus.in_prdata != 0 ||
        bus.in_pslverr)
      leak = 1'b1;
    @(posedge clock);
    #1 bus.in_penable = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.in_pready) begin
        rd = bus.in_prdata;
        er = bus.in_pslverr;
        break;
      end
      if (bus.in_prdata != 0 || bus.in_pslverr)
        leak = 1'b1;
      waits++;
      if (waits > 40) begin
        waits = -1;
        break;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    bus.in_psel    = 1'b0;
    bus.in_penable = 1'b0;
  endtask

  task automatic t(input string tag,
                   input logic        wr,
                   input logic [31:0] a,
                   input logic [31:0] d,
                   input logic [3:0]  s,
                   input logic [2:0]  p,
                   input logic [31:0] exp_rd,
                   input logic        exp_er,
                   input int          exp_w);
    logic [31:0] rd;
    logic        er;
    int          w;
    logic        lk;
    xfer(wr, a, d, s, p, rd, er, w, lk);
    chk({tag, ".waits"}, 32'(w), 32'(exp_w));
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, 32'(er), 32'(exp_er));
    chk({tag, ".idle_out"}, 32'(lk), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_psel    = 1'b0;
    bus.in_penable = 1'b0;
    bus.in_pwrite  = 1'b0;
    bus.in_paddr   = '0;
    bus.in_pwdata  = '0;
    bus.in_pstrb   = '0;
    bus.in_pprot   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.pready",  32'(bus.in_pready), 32'd0);
    chk("rst.prdata",  bus.in_prdata, 32'd0);
    chk("rst.pslverr", 32'(bus.in_pslverr), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    t("w004", 1, 32'h004, 32'hDEADBEEF, 4'hF, 3'b000,
      32'h0, 0, 2);
    t("r004", 0, 32'h004, 32'h0, 4'h0, 3'b000,
      32'hDEADBEEF, 0, 2);
    t("w004b0", 1, 32'h004, 32'h000000AA, 4'h1, 3'b000,
      32'h0, 0, 2);
    t("r004b0", 0, 32'h004, 32'h0, 4'h0, 3'b000,
      32'hDEADBEAA, 0, 2);
    t("w004s0", 1, 32'h004, 32'hFFFFFFFF, 4'h0, 3'b000,
      32'h0, 0, 2);
    t("r004s0", 0, 32'h004, 32'h0, 4'h0, 3'b000,
      32'hDEADBEAA, 0, 2);
    t("wcfg0", 1, 32'h100, 32'h0, 4'hF, 3'b001,
      32'h0, 0, 2);
    t("rcnt7", 0, 32'h104, 32'h0, 4'h0, 3'b000,
      32'd7, 0, 0);
    t("wcfgnp", 1, 32'h100, 32'h5, 4'hF, 3'b000,
      32'h0, 1, 0);
    t("rcfg0", 0, 32'h100, 32'h0, 4'h0, 3'b000,
      32'h0, 0, 0);
    t("r200", 0, 32'h200, 32'h0, 4'h0, 3'b000,
      32'h0, 1, 0);
    t("r006", 0, 32'h006, 32'h0, 4'h0, 3'b000,
      32'h0, 1, 0);
    t("wcnt", 1, 32'h104, 32'h1234, 4'hF, 3'b001,
      32'h0, 1, 0);
    t("wcfg2", 1, 32'h100, 32'hFFFFFF02, 4'h1, 3'b001,
      32'h0, 0, 0);
    t("rcfg2", 0, 32'h100, 32'h0, 4'h0, 3'b000,
      32'h2, 0, 2);

    // Abort a write to 0x008 after one access cycle.
    bus.in_psel    = 1'b1;
    bus.in_penable = 1'b0;
    bus.in_pwrite  = 1'b1;
    bus.in_paddr   = 32'h008;
    bus.in_pwdata  = 32'h11223344;
    bus.in_pstrb   = 4'hF;
    bus.in_pprot   = 3'b000;
    @(posedge clock);
    #1 bus.in_penable = 1'b1;
    @(negedge clock);
    chk("abort.pready", 32'(bus.in_pready), 32'd0);
    @(posedge clock);
    #1 bus.in_psel = 1'b0;
    bus.in_penable = 1'b0;
    @(posedge clock);
    #1;
    t("r008", 0, 32'h008, 32'h0, 4'h0, 3'b000,
      32'h0, 0, 2);
    t("rcnt16", 0, 32'h104, 32'h0, 4'h0, 3'b000,
      32'd16, 0, 2);
    t("wcfg3", 1, 32'h100, 32'h3, 4'h1, 3'b001,
      32'h0, 0, 2);

    // Reset during wait states of a write to 0x00C.
    bus.in_psel    = 1'b1;
    bus.in_penable = 1'b0;
    bus.in_pwrite  = 1'b1;
    bus.in_paddr   = 32'h00C;
    bus.in_pwdata  = 32'hCAFEF00D;
    bus.in_pstrb   = 4'hF;
    bus.in_pprot   = 3'b001;
    @(posedge clock);
    #1 bus.in_penable = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midrst.pready", 32'(bus.in_pready), 32'd0);
    chk("midrst.prdata", bus.in_prdata, 32'd0);
    @(posedge clock);
    #1 bus.in_psel = 1'b0;
    bus.in_penable = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    t("rcnt0", 0, 32'h104, 32'h0, 4'h0, 3'b000,
      32'd0, 0, 2);
    t("rcfgrst", 0, 32'h100, 32'h0, 4'h0, 3'b000,
      32'd2, 0, 2);
    t("r00c", 0, 32'h00C, 32'h0, 4'h0, 3'b000,
      32'h0, 0, 2);
    t("r004rst", 0, 32'h004, 32'h0, 4'h0, 3'b000,
      32'h0, 0, 2);
    t("r03c", 0, 32'h03C, 32'h0, 4'h0, 3'b000,
      32'h0, 0, 2);
    t("r040", 0, 32'h040, 32'h0, 4'h0, 3'b000,
      32'h0, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
